router_sync_np: RTL
===================

Name: router_sync_np

Overview:
Parametrised successor to the 1x3 router synchroniser, generalised to NUM_PORTS output FIFOs.
- Latches the destination address from the header and steers the register block's write strobe to the addressed FIFO.
- Returns the addressed FIFO's full status upstream and drives per-port valid.
- Per-port stall watchdogs issue soft resets after a parametrised timeout.
- New over the 3-port version: invalid-address detection with write suppression, and a run-time timeout enable.

Parameters:
NUM_PORTS, 3, number of output FIFOs/ports (2..8).
ADDR_W, 2, width of header address field; 2**ADDR_W >= NUM_PORTS required.
TIMEOUT, 30, consecutive stalled cycles before soft reset (>= 2).
CNT_W, 5, watchdog counter width; must hold TIMEOUT-1.

Ports:
clock  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
detect_add  input  1  header-byte strobe from FSM; latch data_in.
data_in  input  ADDR_W  destination address field of header.
write_en_reg  input  1  write request from register block.
empty  input  NUM_PORTS  per-FIFO empty flags.
full  input  NUM_PORTS  per-FIFO full flags.
read_en  input  NUM_PORTS  per-FIFO read enables from destination side.
timeout_en  input  1  1 = watchdogs active; 0 = watchdogs cleared and held.
write_en  output  NUM_PORTS  one-hot FIFO write enable.
fifo_full  output  1  full flag of addressed FIFO.
vld_out  output  NUM_PORTS  per-port data valid.
soft_reset  output  NUM_PORTS  one-cycle per-FIFO soft reset pulses.
addr_err  output  1  last latched address >= NUM_PORTS.

Behaviour:
Reset (resetn low, asynchronous):
- addr_q = 0, addr_vld_q = 0, addr_err = 0, all watchdog counters = 0, soft_reset = 0.
- write_en = 0 and fifo_full = 0, because addr_vld_q = 0.

Address latch:
- At a rising edge with detect_add = 1: addr_q <= data_in; addr_vld_q <= 1 if data_in < NUM_PORTS, else 0; addr_err <= ~(data_in < NUM_PORTS).
- addr_q, addr_vld_q and addr_err otherwise hold.
- A new address takes effect the cycle after the detect_add edge; outputs in the detect_add cycle still use the old addr_q.

write_en (combinational from registered state):
- write_en[i] = write_en_reg & addr_vld_q & (addr_q == i).
- Zero hot when the address is invalid; never more than one hot.

fifo_full (combinational):
- fifo_full = full[addr_q] when addr_vld_q, else 0.
- With an invalid address, upstream is not stalled and the packet is silently dropped.

vld_out (combinational):
- vld_out[i] = ~empty[i]; valid during reset as well.

Watchdog, per port i:
- Stall condition: timeout_en & vld_out[i] & ~read_en[i].
- At each rising edge:
  - If stalled and cnt[i] == TIMEOUT-1: soft_reset[i] <= 1, cnt[i] <= 0.
  - Else if stalled: cnt[i] <= cnt[i] + 1, soft_reset[i] <= 0.
  - Else: cnt[i] <= 0, soft_reset[i] <= 0.
- soft_reset[i] is therefore high for exactly one cycle, starting after the TIMEOUT-th consecutive stalled edge.
- read_en[i] high on the terminal edge: no pulse, counter cleared.
- If a FIFO stays non-empty after the pulse, counting restarts from 0.
- Ports are fully independent; several ports may pulse in the same cycle.
- timeout_en low clears all counters within one edge.
- resetn assertion mid-count clears immediately; after release, counting restarts from 0.
- Counters never wrap: the terminal check precedes increment.

Test Plan:
1. resetn=0, empty=111, full=000 -> write_en=000, fifo_full=0, soft_reset=000, addr_err=0, vld_out=000; release resetn -> outputs unchanged.
2. detect_add=1, data_in=01, write_en_reg=1 for one edge -> next cycle write_en=010; full=010 -> fifo_full=1; full=001 -> fifo_full=0.
3. detect_add with data_in=11 (NUM_PORTS=3) -> addr_err=1, write_en=000 with write_en_reg=1, fifo_full=0 with full=111; then data_in=00 -> addr_err=0, write_en=001.
4. timeout_en=1, empty=110, read_en=000 held -> soft_reset=001 for one cycle following the 30th rising edge, else 000; empty kept 110 -> second pulse 30 edges later.
5. Same as 4, but read_en[0]=1 on edge 29 -> no pulse at edge 30; pulse 30 stalled edges after the read. Also: resetn pulsed low at edge 15 -> no pulse until 30 edges after release. Also: timeout_en=0 for 100 cycles -> soft_reset stays 000.
6. Rebuild with NUM_PORTS=4, ADDR_W=2, TIMEOUT=4: data_in=11 -> write_en=1000, addr_err=0; empty=0000 stalled on all ports -> soft_reset=1111 after 4th edge.

Source files
------------

// File: rtl/router_sync_np_if.sv
// Router synchroniser bus: header address, write strobe, FIFO status and per-port controls.
interface router_sync_np_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2
);
    logic                 detect_add;
    logic [ADDR_W-1:0]    data_in;
    logic                 write_en_reg;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] read_en;
    logic                 timeout_en;
    logic [NUM_PORTS-1:0] write_en;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] vld_out;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 addr_err;

    // Upstream / environment side: drives requests and FIFO status
    modport master (
        output detect_add, data_in, write_en_reg, empty, full, read_en, timeout_en,
        input  write_en, fifo_full, vld_out, soft_reset, addr_err
    );

    // Synchroniser side
    modport slave (
        input  detect_add, data_in, write_en_reg, empty, full, read_en, timeout_en,
        output write_en, fifo_full, vld_out, soft_reset, addr_err
    );
endinterface

// File: rtl/router_sync_np.sv
// N-port router synchroniser: address latch, write steering, full mux and stall watchdogs.
module router_sync_np #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned TIMEOUT   = 30,
    parameter int unsigned CNT_W     = 5
) (
    input logic             clock,
    input logic             resetn,
    router_sync_np_if.slave bus
);
    // One extra bit so the range compare cannot overflow when 2**ADDR_W == NUM_PORTS
    localparam int unsigned      CMP_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [ADDR_W-1:0]    addr_q;
    logic                 addr_vld_q;
    logic                 addr_err_q;
    logic                 addr_ok_c;
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] soft_reset_q;
    logic [NUM_PORTS-1:0] stall_c;
    logic [NUM_PORTS-1:0] write_en_c;
    logic [NUM_PORTS-1:0] vld_out_c;
    logic                 fifo_full_c;

    // Header address is usable only if it names an implemented port
    assign addr_ok_c = CMP_W'(bus.data_in) < CMP_W'(NUM_PORTS);

    // Latch destination address and its validity on the header strobe
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else if (bus.detect_add) begin
            addr_q     <= bus.data_in;
            addr_vld_q <= addr_ok_c;
            addr_err_q <= ~addr_ok_c;
        end
    end

    // Steer write strobe and select full flag of the addressed FIFO; invalid address drops the packet
    always_comb begin
        write_en_c  = '0;
        fifo_full_c = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
                write_en_c[i] = bus.write_en_reg;
                fifo_full_c   = bus.full[i];
            end
        end
    end

    // Per-port valid and stall detection
    always_comb begin
        vld_out_c = ~bus.empty;
        stall_c   = {NUM_PORTS{bus.timeout_en}} & vld_out_c & ~bus.read_en;
    end

    // Per-port watchdog: terminal check before increment so the counter never wraps
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
            soft_reset_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (stall_c[i] && (cnt_q[i] == CNT_LAST)) begin
                    soft_reset_q[i] <= 1'b1;
                    cnt_q[i]        <= '0;
                end else if (stall_c[i]) begin
                    soft_reset_q[i] <= 1'b0;
                    cnt_q[i]        <= cnt_q[i] + CNT_W'(1);
                end else begin
                    soft_reset_q[i] <= 1'b0;
                    cnt_q[i]        <= '0;
                end
            end
        end
    end

    assign bus.write_en   = write_en_c;
    assign bus.fifo_full  = fifo_full_c;
    assign bus.vld_out    = vld_out_c;
    assign bus.soft_reset = soft_reset_q;
    assign bus.addr_err   = addr_err_q;

endmodule
